// File: rtl/instr_mem_loadable.sv
// Instruction memory with a streaming boot-load port and a registered fetch port.
// Latency: fetch data, valid and fault appear one cycle after an accepted fetch.
// Backpressure: load_ready is high only while loading; fetches are not served while busy.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   fetch_en, pc      fetch request and byte address (word index = pc[PC_W-1:1])
//   instruction       registered fetched word (HALT_WORD on a faulting fetch)
//   instr_valid       instruction was updated by a fetch accepted last cycle
//   fault             last accepted fetch was misaligned or out of range
//   busy              a program load is in progress
//   load_start        begin a program load (only honoured when idle)
//   load_valid/_data  program word stream, load_last marks the final word
//   load_ready        a word is accepted this cycle
//   load_done         one-cycle pulse after the final word is written
//   load_count        number of words written by the most recent completed load
module instr_mem_loadable #(
  parameter int                DATA_W    = 16,
  parameter int                PC_W      = 16,
  parameter int                DEPTH     = 256,
  parameter logic [DATA_W-1:0] HALT_WORD = 16'hE000,
  parameter int                CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic              fault,
  output logic              busy,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic [CNT_W-1:0]  load_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  load_count_q, load_count_d;
  logic              load_done_q, load_done_d;

  logic [DATA_W-1:0] instr_q;
  logic              instr_valid_q;
  logic              fault_q;

  // Program store. Not touched by reset, so a program survives a core reset;
  // it powers up full of halt instructions so an unloaded core stops cleanly.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: HALT_WORD};

  // ---------------------------------------------------------------------------
  // Load side
  // ---------------------------------------------------------------------------
  logic load_accept;
  logic load_term;
  logic ptr_at_end;

  assign ptr_at_end  = (wr_ptr_q == AW'(DEPTH - 1));
  assign load_accept = load_valid & (state_q == ST_LOAD);
  // A load ends on the tagged last word, or when the array is full.
  assign load_term   = load_accept & (load_last | ptr_at_end);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    load_count_d = load_count_q;
    load_done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
        end
      end
      ST_LOAD: begin
        if (load_accept) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (load_term) begin
          state_d      = ST_IDLE;
          // Words written includes the one accepted on this edge (1..DEPTH).
          load_count_d = CNT_W'(wr_ptr_q) + CNT_W'(1);
          load_done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      load_count_q <= '0;
      load_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      load_count_q <= load_count_d;
      load_done_q  <= load_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_accept) begin
      mem_q[wr_ptr_q] <= load_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch side
  // ---------------------------------------------------------------------------
  logic              fetch_accept;
  logic [PC_W-2:0]   fetch_idx;
  logic              fetch_misaligned;
  logic              fetch_oor;
  logic              fetch_fault;

  assign fetch_accept     = fetch_en & (state_q == ST_IDLE);
  assign fetch_idx        = pc[PC_W-1:1];
  assign fetch_misaligned = pc[0];
  // Zero-extend to PC_W bits so DEPTH == 2^(PC_W-1) is still representable.
  assign fetch_oor        = ({1'b0, fetch_idx} >= PC_W'(DEPTH));
  assign fetch_fault      = fetch_misaligned | fetch_oor;

  // Fetch and load are mutually exclusive by state, so the read below never
  // overlaps a write to the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else if (fetch_accept) begin
      instr_valid_q <= 1'b1;
      if (fetch_fault) begin
        instr_q <= HALT_WORD;
        fault_q <= 1'b1;
      end else begin
        instr_q <= mem_q[fetch_idx[AW-1:0]];
        fault_q <= 1'b0;
      end
    end else begin
      // instruction and fault hold; only the valid flag drops.
      instr_valid_q <= 1'b0;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = instr_valid_q;
  assign fault       = fault_q;
  assign busy        = (state_q == ST_LOAD);
  assign load_ready  = (state_q == ST_LOAD);
  assign load_done   = load_done_q;
  assign load_count  = load_count_q;

endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
Parametrised instruction memory for the 16-bit MIPS core, replacing the fixed 16-word program store. It adds a boot-load port that streams a program into the array at run time, and a registered fetch port with a valid flag. It also flags misaligned and out-of-range fetches. The block sits between the PC register and the decode stage; the loader side connects to the bench or a UART boot block.

Parameters:
DATA_W, 16, instruction word width in bits
PC_W, 16, byte-address width of pc
DEPTH, 256, number of instruction words (power of two, ≥2, ≤ 2^(PC_W-1))
HALT_WORD, 16'hE000, word returned on faulting fetch (opcode 111 = hlt)
CNT_W, $clog2(DEPTH)+1, width of load_count

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
fetch_en  in  1  request fetch of word at pc this cycle
pc  in  PC_W  byte address; word index = pc[PC_W-1:1]
instruction  out  DATA_W  registered fetched word
instr_valid  out  1  instruction updated by a fetch accepted last cycle
fault  out  1  last accepted fetch was misaligned or out of range
busy  out  1  block is in LOAD; fetches are not served
load_start  in  1  begin program load (sampled in IDLE only)
load_valid  in  1  load_data holds a word
load_data  in  DATA_W  program word
load_last  in  1  qualifies final word of the stream
load_ready  out  1  block accepts a word this cycle
load_done  out  1  one-cycle pulse at end of load
load_count  out  CNT_W  words written by the most recent load

Behaviour:
- Reset (rst_n=0, async): state=IDLE, write pointer=0. instruction=0, instr_valid=0, fault=0, busy=0, load_ready=0, load_done=0, load_count=0. Array contents are not cleared by reset.
- Array power-up contents: every word = HALT_WORD.
- FSM states: IDLE and LOAD.
- IDLE → LOAD when load_start=1. Write pointer is cleared to 0 on that edge.
- LOAD → IDLE on an accepted word with load_last=1, or on an accepted word written at index DEPTH-1 (auto-terminate).
- Other inputs in LOAD are ignored, including load_start.
- In LOAD: busy=1, load_ready=1 (combinational from state).
  - Accept = load_valid & load_ready. On accept: mem[ptr] ← load_data, ptr ← ptr+1.
  - On the terminating edge: load_count ← words written (1..DEPTH), and load_done=1 for exactly the following cycle.
- load_count holds its value until the next completed load or reset. It is not updated while a load is in progress.
- Fetch accept = fetch_en & (state==IDLE).
  - On accept, one cycle later: instr_valid=1, and instruction = mem[pc[PC_W-1:1]].
  - If pc[0]=1 or the word index ≥ DEPTH: instruction=HALT_WORD and fault=1 instead.
  - Otherwise fault=0.
- Cycle with no fetch accept: instr_valid=0 next cycle. instruction and fault hold their previous values.
- Fetch_en while in LOAD: not accepted, no error.
- Read-during-write is impossible, because fetch and load are exclusive by state.
- Same cycle as load_start in IDLE: a fetch_en is still accepted (old contents); LOAD is entered next cycle.
- Reset mid-load: the FSM returns to IDLE and load_done does not pulse. Words already written remain; load_count=0.
- Implementation: synchronous-read register array of DEPTH×DATA_W; no combinational path from pc to instruction.

Test Plan:
1. Load 8 words {0x2082,0x2106,0x2188,0x0C80,0x0C90,0x7101,0xA003,0xE000}, last on the 8th → load_ready high for the load, load_done pulses once, load_count=8. Then fetch pc=0,2,…,14 back-to-back → the same words appear one cycle after each fetch, instr_valid=1 each cycle, fault=0.
2. Fetch pc=3 → instruction=0xE000, fault=1, instr_valid=1. Then fetch pc=4 → 0x2188, fault=0.
3. DEPTH=256: fetch pc=0x0200 (index 256) → 0xE000, fault=1. Fetch pc=0x01FE → mem[255].
4. Stream 256 words without load_last → auto-terminate after word 256, load_count=256. A 257th load_valid is not accepted (load_ready=0, busy=0).
5. Assert fetch_en throughout a load → instr_valid=0 from the cycle after LOAD entry until after return to IDLE. Also, fetch_en with load_start in the same cycle → that one fetch is served.
6. Reset asynchronously after 3 words of a 6-word load → busy, load_ready, instr_valid and load_count are 0 immediately, with no load_done. Fetch word 2 → new data; fetch word 3 → previous content.
